// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake fabric: default payload width/value
// and a constant-evaluable ceil(log2) for sizing counters.
package handshake_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam logic [31:0] DEFAULT_VALUE      = 32'h0000_0CE7;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/handshake_token_counter.sv
// Up/down count of owed output tokens: +REPEAT per accepted trigger, -1 per
// emitted token. Callers gate inc/dec so the range stays within 0..2*REPEAT.
module handshake_token_counter
  import handshake_pkg::*;
#(
  parameter int unsigned REPEAT = 1,
  parameter int unsigned CNT_W  = clog2(2 * REPEAT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             is_zero_o,
  output logic             le_repeat_o
);

  localparam logic [CNT_W-1:0] STEP_UP = CNT_W'(REPEAT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + (inc_i ? STEP_UP : '0) - (dec_i ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign is_zero_o   = (count_q == '0);
  assign le_repeat_o = (count_q <= STEP_UP);

endmodule

// File: rtl/handshake_constant_repeat.sv
// Constant source: each accepted ctrl token yields REPEAT copies of VALUE.
// All handshake outputs decode from the registered pending count only.
module handshake_constant_repeat
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [31:0] VALUE      = DEFAULT_VALUE,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last
);

  localparam int unsigned           CNT_W     = clog2(2 * REPEAT + 1);
  localparam logic [DATA_WIDTH-1:0] OUT_CONST = DATA_WIDTH'(VALUE);
  localparam logic [CNT_W-1:0]      LAST_A    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      LAST_B    = CNT_W'(REPEAT + 1);

  if (REPEAT < 1) begin : g_bad_repeat
    $error("handshake_constant_repeat: REPEAT must be >= 1");
  end

  logic [CNT_W-1:0] pending;
  logic             is_zero;
  logic             le_repeat;
  logic             ctrl_fire;
  logic             outs_fire;

  assign ctrl_fire = ctrl_valid & ctrl_ready;
  assign outs_fire = outs_valid & outs_ready;

  handshake_token_counter #(
    .REPEAT (REPEAT),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk_i       (clk),
    .rst_ni      (rst),
    .inc_i       (ctrl_fire),
    .dec_i       (outs_fire),
    .count_o     (pending),
    .is_zero_o   (is_zero),
    .le_repeat_o (le_repeat)
  );

  // rst gating keeps handshakes dead while reset is asserted, even though
  // the counter at zero would otherwise report ready.
  always_comb begin
    outs_valid = 1'b0;
    ctrl_ready = 1'b0;
    outs_last  = 1'b0;
    if (rst) begin
      outs_valid = !is_zero;
      ctrl_ready = le_repeat;
      outs_last  = !is_zero && ((pending == LAST_A) || (pending == LAST_B));
    end
  end

  assign outs = OUT_CONST;

endmodule

// File: tb/tb_handshake_constant_repeat.sv
// Bench for handshake_constant_repeat: a REPEAT=1/32-bit and a REPEAT=3/8-bit
// instance checked each cycle against a queue of owed copies (last flags).
module tb_handshake_constant_repeat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, cv1, rdy1, vld1, or1, last1;
  logic [31:0] outs1;
  logic        rst3, cv3, rdy3, vld3, or3, last3;
  logic [7:0]  outs3;

  int tests = 0;
  int fails = 0;
  int q1[$];
  int q3[$];
  int o1_cnt, l1_cnt, c1_cnt;
  int o3_cnt, l3_cnt, c3_cnt;

  handshake_constant_repeat #(
    .DATA_WIDTH (32),
    .VALUE      (32'h0000_0CE7),
    .REPEAT     (1)
  ) u_d1 (
    .clk        (clk),
    .rst        (rst1),
    .ctrl_valid (cv1),
    .ctrl_ready (rdy1),
    .outs       (outs1),
    .outs_valid (vld1),
    .outs_ready (or1),
    .outs_last  (last1)
  );

  handshake_constant_repeat #(
    .DATA_WIDTH (8),
    .VALUE      (32'h0000_0CE7),
    .REPEAT     (3)
  ) u_d3 (
    .clk        (clk),
    .rst        (rst3),
    .ctrl_valid (cv3),
    .ctrl_ready (rdy3),
    .outs       (outs3),
    .outs_valid (vld3),
    .outs_ready (or3),
    .outs_last  (last3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    o1_cnt = 0; l1_cnt = 0; c1_cnt = 0;
    o3_cnt = 0; l3_cnt = 0; c3_cnt = 0;
  endtask

  // One clock: check outputs at negedge, advance the reference at posedge.
  task automatic tick();
    bit erdy1, evld1, elast1, erdy3, evld3, elast3;
    bit ef1, eo1, ef3, eo3;
    @(negedge clk);
    erdy1  = rst1 && (q1.size() <= 1);
    evld1  = rst1 && (q1.size() != 0);
    elast1 = (evld1 && q1.size() > 0) ? (q1[0] != 0) : 1'b0;
    erdy3  = rst3 && (q3.size() <= 3);
    evld3  = rst3 && (q3.size() != 0);
    elast3 = (evld3 && q3.size() > 0) ? (q3[0] != 0) : 1'b0;
    chk("d1_ready", rdy1, erdy1);
    chk("d1_valid", vld1, evld1);
    chk("d1_last",  last1, elast1);
    chk("d1_outs",  outs1, 32'h0000_0CE7);
    chk("d3_ready", rdy3, erdy3);
    chk("d3_valid", vld3, evld3);
    chk("d3_last",  last3, elast3);
    chk("d3_outs",  outs3, 8'hE7);
    chk("d3_pmax",  (u_d3.u_cnt.count_q <= 3'd6), 1'b1);
    chk("d1_pmax",  (u_d1.u_cnt.count_q <= 2'd2), 1'b1);
    ef1 = cv1 && erdy1;
    eo1 = evld1 && or1;
    ef3 = cv3 && erdy3;
    eo3 = evld3 && or3;
    if (cv1 && rdy1) c1_cnt++;
    if (vld1 && or1) begin o1_cnt++; if (last1) l1_cnt++; end
    if (cv3 && rdy3) c3_cnt++;
    if (vld3 && or3) begin o3_cnt++; if (last3) l3_cnt++; end
    @(posedge clk);
    #1;
    if (!rst1) q1.delete();
    else begin
      if (eo1) void'(q1.pop_front());
      if (ef1) q1.push_back(1);
    end
    if (!rst3) q3.delete();
    else begin
      if (eo3) void'(q3.pop_front());
      if (ef3) begin q3.push_back(0); q3.push_back(0); q3.push_back(1); end
    end
  endtask

  initial begin
    clear_counts();
    rst1 = 1'b0; rst3 = 1'b0;
    cv1 = 1'b1; cv3 = 1'b1; or1 = 1'b0; or3 = 1'b0;
    repeat (5) tick();
    rst1 = 1'b1; rst3 = 1'b1; cv1 = 1'b0; cv3 = 1'b0;
    tick();

    // Streaming, REPEAT=1
    clear_counts();
    cv1 = 1'b1; or1 = 1'b1;
    repeat (10) tick();
    cv1 = 1'b0;
    repeat (2) tick();
    chk("d1_stream_tokens", o1_cnt, 10);
    chk("d1_stream_lasts",  l1_cnt, 10);

    // Backpressure, REPEAT=1
    or1 = 1'b0; cv1 = 1'b1;
    repeat (4) tick();
    chk("d1_bp_pending", u_d1.u_cnt.count_q, 2);
    clear_counts();
    or1 = 1'b1; cv1 = 1'b0;
    repeat (3) tick();
    chk("d1_bp_drained", o1_cnt, 2);
    or1 = 1'b0;

    // Two groups, REPEAT=3, second accepted during drain
    clear_counts();
    or3 = 1'b1; cv3 = 1'b1;
    tick();
    cv3 = 1'b0;
    tick();
    cv3 = 1'b1;
    tick();
    cv3 = 1'b0;
    repeat (6) tick();
    chk("d3_group_tokens", o3_cnt, 6);
    chk("d3_group_lasts",  l3_cnt, 2);

    // Random stall on both instances
    clear_counts();
    for (int i = 0; i < 2000; i++) begin
      cv1 = 1'($urandom_range(0, 1));
      or1 = 1'($urandom_range(0, 1));
      cv3 = 1'($urandom_range(0, 1));
      or3 = 1'($urandom_range(0, 1));
      tick();
    end
    cv1 = 1'b0; cv3 = 1'b0; or1 = 1'b1; or3 = 1'b1;
    repeat (8) tick();
    chk("d1_rand_tokens", o1_cnt, c1_cnt);
    chk("d1_rand_lasts",  l1_cnt, c1_cnt);
    chk("d3_rand_tokens", o3_cnt, 3 * c3_cnt);
    chk("d3_rand_lasts",  l3_cnt, c3_cnt);
    chk("d3_rand_activity", (c3_cnt > 0), 1'b1);

    // Reset mid-group, REPEAT=3
    or1 = 1'b0;
    or3 = 1'b1; cv3 = 1'b1;
    tick();
    cv3 = 1'b0;
    tick();
    #2;
    rst3 = 1'b0;
    #1;
    chk("d3_async_valid", vld3, 1'b0);
    chk("d3_async_ready", rdy3, 1'b0);
    chk("d3_async_pend",  u_d3.u_cnt.count_q, 0);
    repeat (2) tick();
    rst3 = 1'b1;
    clear_counts();
    repeat (4) tick();
    chk("d3_after_reset_tokens", o3_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
